// File: rtl/uart_pkg.sv
// Shared UART package: oversampling resolution and the one-hot state
// constants of the transmit arbiter.
package uart_pkg;

  localparam int BIT_RESOLUTION = 16;

  localparam int ARB_NSTATES = 4;

  typedef logic [ARB_NSTATES-1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 4'b0001;
  localparam arb_state_t ARB_START = 4'b0010;
  localparam arb_state_t ARB_WAIT  = 4'b0100;
  localparam arb_state_t ARB_GAP   = 4'b1000;

endpackage

// File: rtl/uart_rr_pick.sv
// Winner picker for the UART TX arbiter. Purely combinational.
// With UART_TX_ARB_RR_EN defined the search starts at the rotating pointer;
// otherwise the lowest asserted index wins and no pointer port exists.
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid,
`ifdef UART_TX_ARB_RR_EN
  input  logic [$clog2(NREQ)-1:0] ptr,
`endif
  output logic [NREQ-1:0]         winner,
  output logic [$clog2(NREQ)-1:0] winner_idx,
  output logic                    any_valid
);

  localparam int IW = $clog2(NREQ);

`ifdef UART_TX_ARB_RR_EN
  // Scan offsets from farthest to nearest so the requester closest to the
  // pointer (in wrap-around order) is the one left standing.
  always_comb begin
    int idx;
    idx        = 0;
    winner     = '0;
    winner_idx = '0;
    any_valid  = |req_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        winner_idx  = IW'(idx);
      end
    end
  end
`else
  // Fixed priority: scan from the top so the lowest asserted index wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any_valid  = |req_valid;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner     = '0;
        winner[i]  = 1'b1;
        winner_idx = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART TX arbiter: shares one transmitter between NREQ producers. Accepts a
// word over valid/ready, pulses tx_start for one cycle, holds tx_data, and
// waits for tx_done (plus GAP_CYCLES idle cycles) before granting again.
// Optional feature: define UART_TX_ARB_RR_EN for round-robin selection;
// the default build uses fixed lowest-index priority.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int WORD_WIDTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WORD_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       tx_start,
  output logic [WORD_WIDTH-1:0]      tx_data,
  input  logic                       tx_done,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  import uart_pkg::*;

  localparam int IW         = $clog2(NREQ);
  // Keep the counter at least one bit wide so the GAP_CYCLES=0 build elaborates.
  localparam int GW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [NREQ-1:0]       winner;
  logic [IW-1:0]         winner_idx;
  logic                  any_valid;
  logic                  transfer;
  logic [GW-1:0]         gap_cnt;
  logic [WORD_WIDTH-1:0] words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign words[i] = req_data[i*WORD_WIDTH +: WORD_WIDTH];
  end

`ifdef UART_TX_ARB_RR_EN
  logic [IW-1:0] ptr;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid  (req_valid),
    .ptr        (ptr),
    .winner     (winner),
    .winner_idx (winner_idx),
    .any_valid  (any_valid)
  );

  // Rotate the search start to just past the last winner, only on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (winner_idx == IW'(NREQ - 1)) ? '0 : winner_idx + 1'b1;
    end
  end
`else
  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid  (req_valid),
    .winner     (winner),
    .winner_idx (winner_idx),
    .any_valid  (any_valid)
  );
`endif

  assign transfer = |(req_valid & req_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; tx_done only matters while waiting on the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (transfer) state_nxt = ARB_START;
      ARB_START: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (tx_done) state_nxt = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
      ARB_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs decoded from the state register; ready is gated off during reset.
  always_comb begin
    req_ready = '0;
    if (state == ARB_IDLE && !reset && any_valid) req_ready = winner;
    tx_start  = (state == ARB_START);
    busy      = (state != ARB_IDLE);
  end

  // Inter-frame gap counter, cleared on entry to GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == ARB_WAIT && tx_done) begin
      gap_cnt <= '0;
    end else if (state == ARB_GAP) begin
      gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
    end
  end

  // Capture the accepted word and its source; held until the next transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data  <= '0;
      grant_id <= '0;
    end else if (transfer) begin
      tx_data  <= words[winner_idx];
      grant_id <= winner_idx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Two instances: GAP_CYCLES=0 (dut0) and
// GAP_CYCLES=3 (dut3). Expected grants come from a queue-free arithmetic
// model of the selection rule; honours UART_TX_ARB_RR_EN.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
`ifdef UART_TX_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NREQ-1:0]  rv0, rv3;
  logic [NREQ*W-1:0] rd0, rd3;
  logic             td0, td3;
  logic [NREQ-1:0]  rr0, rr3;
  logic             ts0, ts3, busy0, busy3;
  logic [W-1:0]     tdat0, tdat3;
  logic [1:0]       gid0, gid3;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .WORD_WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
    .tx_start(ts0), .tx_data(tdat0), .tx_done(td0), .grant_id(gid0), .busy(busy0)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .WORD_WIDTH(W), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
    .tx_start(ts3), .tx_data(tdat3), .tx_done(td3), .grant_id(gid3), .busy(busy3)
  );

  // Advance into the next cycle, well clear of the active edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle;
    #1;
  endtask

  // Selection rule: first valid index scanning upward from the pointer.
  function automatic int model_pick(input logic [3:0] m);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (mptr + k) % NREQ;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int w);
    mptr = RR_MODE ? (w + 1) % NREQ : 0;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset;
    reset = 1'b1; rv0 = '0; rv3 = '0; td0 = 1'b0; td3 = 1'b0;
    tick; tick;
    reset = 1'b0; mptr = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rv0 = 4'b1111; rv3 = 4'b1111; td0 = 1'b0; td3 = 1'b0;
    rd0 = $urandom; rd3 = $urandom;
    tick; settle;
    checks++; if (rr0 !== 4'b0000) begin errors++; $display("FAIL rst_ready0 got %b exp 0000", rr0); end
    checks++; if (rr3 !== 4'b0000) begin errors++; $display("FAIL rst_ready3 got %b exp 0000", rr3); end
    checks++; if (ts0 !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", ts0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy0); end
    checks++; if (tdat0 !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", tdat0); end
    checks++; if (gid0 !== 2'd0) begin errors++; $display("FAIL rst_gid got %0d exp 0", gid0); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy3 got %b exp 0", busy3); end
    tick; settle;
    checks++; if (rr0 !== 4'b0000) begin errors++; $display("FAIL rst_ready_hold got %b exp 0000", rr0); end
    rv0 = '0; rv3 = '0; reset = 1'b0; mptr = 0;
    tick;
  endtask

  task automatic test_single;
    rd0 = $urandom; rd0[15:8] = 8'hA5; rv0 = 4'b0010; settle;
    checks++; if (rr0 !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", rr0); end
    tick; rv0 = '0; settle;
    model_grant(1);
    checks++; if (ts0 !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", ts0); end
    checks++; if (tdat0 !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", tdat0); end
    checks++; if (gid0 !== 2'd1) begin errors++; $display("FAIL single_gid got %0d exp 1", gid0); end
    checks++; if (rr0 !== 4'b0000) begin errors++; $display("FAIL single_ready_off got %b exp 0000", rr0); end
    tick;
    checks++; if (ts0 !== 1'b0) begin errors++; $display("FAIL single_start_once got %b exp 0", ts0); end
    tick; tick;
    td0 = 1'b1; settle;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy_wait got %b exp 1", busy0); end
    tick; td0 = 1'b0; settle;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_done got %b exp 0", busy0); end
    checks++; if (tdat0 !== 8'hA5) begin errors++; $display("FAIL single_data_held got %h exp a5", tdat0); end
  endtask

  task automatic test_order;
    int ng;
    int exp;
    int waited;
    do_reset;
    ng = RR_MODE ? 5 : 3;
    rv0 = 4'b1111; rd0 = $urandom;
    for (int g = 0; g < ng; g++) begin
      exp = model_pick(4'b1111);
      waited = 0;
      settle;
      while (ts0 !== 1'b1 && waited < 12) begin
        checks++;
        if (rr0 !== 4'b0000 && rr0 !== onehot(exp)) begin
          errors++; $display("FAIL order_ready got %b exp %b or 0000", rr0, onehot(exp));
        end
        tick; settle; waited++;
      end
      checks++; if (ts0 !== 1'b1) begin errors++; $display("FAIL order_timeout got %b exp 1", ts0); end
      checks++; if (gid0 !== 2'(exp)) begin errors++; $display("FAIL order_gid got %0d exp %0d", gid0, exp); end
      checks++; if (tdat0 !== rd0[exp*W +: W]) begin errors++; $display("FAIL order_data got %h exp %h", tdat0, rd0[exp*W +: W]); end
      model_grant(exp);
      repeat (20) tick;
      td0 = 1'b1;
      if (g == ng - 1) rv0 = '0;
      tick; td0 = 1'b0;
    end
  endtask

  task automatic test_stray_done;
    logic [7:0] w2;
    td0 = 1'b1; tick; td0 = 1'b0; settle;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL stray_idle_busy got %b exp 0", busy0); end
    checks++; if (ts0 !== 1'b0) begin errors++; $display("FAIL stray_idle_start got %b exp 0", ts0); end
    rd0 = $urandom; rv0 = 4'b0100; settle;
    checks++; if (rr0 !== 4'b0100) begin errors++; $display("FAIL stray_ready got %b exp 0100", rr0); end
    tick; rv0 = '0; td0 = 1'b1; settle;
    model_grant(2);
    checks++; if (ts0 !== 1'b1) begin errors++; $display("FAIL stray_start got %b exp 1", ts0); end
    tick; td0 = 1'b0; settle;
    checks++; if (ts0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL stray_start_wait got start=%b busy=%b exp start=0 busy=1", ts0, busy0); end
    tick;
    checks++; if (ts0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL stray_still_wait got start=%b busy=%b exp start=0 busy=1", ts0, busy0); end
    w2 = 8'($urandom); rd0[23:16] = w2; rv0 = 4'b0100; td0 = 1'b1; settle;
    checks++; if (rr0 !== 4'b0000) begin errors++; $display("FAIL coinc_ready_wait got %b exp 0000", rr0); end
    tick; td0 = 1'b0; settle;
    checks++; if (busy0 !== 1'b0 || rr0 !== 4'b0100) begin errors++; $display("FAIL coinc_idle got busy=%b ready=%b exp busy=0 ready=0100", busy0, rr0); end
    tick; rv0 = '0; settle;
    model_grant(2);
    checks++; if (ts0 !== 1'b1) begin errors++; $display("FAIL coinc_start got %b exp 1", ts0); end
    checks++; if (tdat0 !== w2 || gid0 !== 2'd2) begin errors++; $display("FAIL coinc_word got %h/%0d exp %h/2", tdat0, gid0, w2); end
    tick; tick; tick;
    td0 = 1'b1; tick; td0 = 1'b0;
  endtask

  task automatic test_reset_wait;
    int exp;
    rd0 = $urandom | 32'h0001_0101; rv0 = 4'b0100; settle;
    tick; rv0 = '0; model_grant(2);
    tick; tick;
    reset = 1'b1; rv0 = 4'b1111; rd0 = $urandom; settle;
    checks++; if (rr0 !== 4'b0000) begin errors++; $display("FAIL rstw_ready_wait got %b exp 0000", rr0); end
    tick; settle;
    checks++; if (busy0 !== 1'b0 || ts0 !== 1'b0) begin errors++; $display("FAIL rstw_state got busy=%b start=%b exp 0/0", busy0, ts0); end
    checks++; if (tdat0 !== 8'h00 || gid0 !== 2'd0) begin errors++; $display("FAIL rstw_regs got %h/%0d exp 00/0", tdat0, gid0); end
    checks++; if (rr0 !== 4'b0000) begin errors++; $display("FAIL rstw_ready_rst got %b exp 0000", rr0); end
    reset = 1'b0; mptr = 0; settle;
    exp = model_pick(4'b1111);
    checks++; if (rr0 !== onehot(exp)) begin errors++; $display("FAIL rstw_first_ready got %b exp %b", rr0, onehot(exp)); end
    tick; rv0 = '0; settle;
    checks++; if (ts0 !== 1'b1 || gid0 !== 2'(exp)) begin errors++; $display("FAIL rstw_first_grant got start=%b gid=%0d exp 1/%0d", ts0, gid0, exp); end
    model_grant(exp);
    tick; tick;
    td0 = 1'b1; tick; td0 = 1'b0;
  endtask

  task automatic test_gap;
    for (int f = 0; f < 2; f++) begin
      rv3 = 4'b1000; rd3 = $urandom; settle;
      checks++; if (rr3 !== 4'b1000) begin errors++; $display("FAIL gap_ready got %b exp 1000", rr3); end
      tick; settle;
      checks++; if (ts3 !== 1'b1 || tdat3 !== rd3[31:24]) begin errors++; $display("FAIL gap_start got %b/%h exp 1/%h", ts3, tdat3, rd3[31:24]); end
      tick; tick; tick;
      td3 = 1'b1; tick; td3 = 1'b0;
      for (int j = 1; j <= 3; j++) begin
        td3 = (f == 1 && j == 2);
        settle;
        checks++; if (busy3 !== 1'b1 || rr3 !== 4'b0000) begin errors++; $display("FAIL gap_hold_%0d got busy=%b ready=%b exp 1/0000", j, busy3, rr3); end
        tick;
      end
      td3 = 1'b0; settle;
      checks++; if (busy3 !== 1'b0 || rr3 !== 4'b1000) begin errors++; $display("FAIL gap_release got busy=%b ready=%b exp 0/1000", busy3, rr3); end
    end
    rv3 = '0; tick;
  endtask

  task automatic test_random_traffic;
    logic [3:0] m;
    logic [7:0] word;
    int exp;
    int len;
    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom_range(0, 15)); rd0 = $urandom; rv0 = m; settle;
      exp = model_pick(m);
      checks++; if (busy0 !== 1'b0 || rr0 !== onehot(exp)) begin errors++; $display("FAIL rand_ready r%0d got busy=%b ready=%b exp 0/%b", r, busy0, rr0, onehot(exp)); end
      if (exp < 0) begin
        tick;
      end else begin
        word = rd0[exp*W +: W];
        tick; settle;
        checks++; if (ts0 !== 1'b1 || gid0 !== 2'(exp) || tdat0 !== word) begin
          errors++; $display("FAIL rand_grant r%0d got start=%b gid=%0d data=%h exp 1/%0d/%h", r, ts0, gid0, tdat0, exp, word);
        end
        model_grant(exp);
        len = $urandom_range(1, 4);
        for (int c = 0; c < len; c++) begin
          tick;
          checks++; if (ts0 !== 1'b0 || busy0 !== 1'b1 || tdat0 !== word) begin
            errors++; $display("FAIL rand_wait r%0d got start=%b busy=%b data=%h exp 0/1/%h", r, ts0, busy0, tdat0, word);
          end
        end
        td0 = 1'b1; tick; td0 = 1'b0;
      end
    end
    rv0 = '0;
  endtask

  initial begin
    reset = 1'b1; rv0 = '0; rv3 = '0; rd0 = '0; rd3 = '0; td0 = 1'b0; td3 = 1'b0;
    test_reset;
    test_single;
    test_order;
    test_stray_done;
    test_reset_wait;
    test_gap;
    test_random_traffic;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
